// File: rtl/fsm_seq_ctrl_pkg.sv
// fsm_pkg: types shared by the sequencer and the benches that sit around it.
//   phase_e     - controller phase encodings (IDLE, PH1..PH4)
//   fsm_state_e - state codes of the attached Idle/Start/Stop/Clear FSM,
//                 kept here so monitors decode them the same way everywhere
package fsm_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_1    = 3'd1,
    PH_2    = 3'd2,
    PH_3    = 3'd3,
    PH_4    = 3'd4
  } phase_e;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'b00,
    FSM_START = 2'b01,
    FSM_STOP  = 2'b10,
    FSM_CLEAR = 2'b11
  } fsm_state_e;

endpackage

// File: rtl/fsm_seq_ctrl_phase_timer.sv
// phase_timer: loadable down-counter timing one sequencer phase.
//   Clock, Reset - clock and async active-low reset
//   load         - reload the counter with load_val (phase length minus one)
//   load_val     - first count of the phase
//   expire       - high in the last cycle of the phase (count has reached 0)
module phase_timer #(
  parameter int HOLD_W = 8
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          load,
  input  logic [HOLD_W:0] load_val,
  output logic          expire
);

  logic [HOLD_W:0] cnt;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/fsm_seq_ctrl.sv
// fsm_seq_ctrl: drives A of the Idle/Start/Stop/Clear FSM through N full
// rounds and checks the K2/K1 pulses it returns.
//   Clock, Reset      - clock and async active-low reset
//   start             - launch request, ignored while busy
//   hold_cycles       - extra cycles per phase (phase length = hold + 2)
//   num_rounds        - rounds to run; 0 just pulses done
//   K2, K1            - FSM responses, expected in PH3 and PH4 respectively
//   A                 - registered drive to FSM A
//   busy, done, err   - run in progress, one-cycle completion, sticky error
//   rounds_done       - rounds completed without error
//
// state   | meaning
// PH_IDLE | waiting for start, A=0
// PH_1    | A=1, FSM Idle->Start
// PH_2    | A=0, FSM Start->Stop
// PH_3    | A=1, FSM Stop->Clear, K2 expected
// PH_4    | A=0, FSM Clear->Idle, K1 expected
module fsm_seq_ctrl
  import fsm_pkg::*;
#(
  parameter int HOLD_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              start,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic [CNT_W-1:0]  num_rounds,
  input  logic              K2,
  input  logic              K1,
  output logic              A,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  rounds_done
);

  localparam logic [HOLD_W:0] ONE_T = (HOLD_W+1)'(1);
  localparam logic [CNT_W-1:0] ONE_R = CNT_W'(1);

  phase_e            phase;
  logic [HOLD_W-1:0] h_lat;
  logic [CNT_W-1:0]  n_lat;
  logic              k2_seen, k1_seen;
  logic              expire, t_load;
  logic [HOLD_W:0]   t_val;
  logic              misplaced, missing, abort, last_round;

  // While idle the timer keeps tracking the live hold input so it already
  // holds L-1 on the edge that accepts start.
  assign t_load = (phase == PH_IDLE) || expire;
  assign t_val  = ((phase == PH_IDLE) ? {1'b0, hold_cycles} : {1'b0, h_lat}) + ONE_T;

  phase_timer #(.HOLD_W(HOLD_W)) u_timer (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (t_load),
    .load_val (t_val),
    .expire   (expire)
  );

  always_comb begin
    misplaced  = (K1 && (phase == PH_1 || phase == PH_2 || phase == PH_3)) ||
                 (K2 && (phase == PH_1 || phase == PH_2 || phase == PH_4));
    // The pulse sampled on the exit edge itself still counts.
    missing    = expire && ((phase == PH_3 && !(k2_seen || K2)) ||
                            (phase == PH_4 && !(k1_seen || K1)));
    abort      = misplaced || missing;
    last_round = ((rounds_done + ONE_R) == n_lat);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      phase       <= PH_IDLE;
      A           <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      rounds_done <= '0;
      h_lat       <= '0;
      n_lat       <= '0;
      k2_seen     <= 1'b0;
      k1_seen     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (phase == PH_IDLE) begin
        if (start) begin
          h_lat       <= hold_cycles;
          n_lat       <= num_rounds;
          err         <= 1'b0;
          rounds_done <= '0;
          k2_seen     <= 1'b0;
          k1_seen     <= 1'b0;
          if (num_rounds == '0) begin
            done <= 1'b1;
          end else begin
            phase <= PH_1;
            A     <= 1'b1;
            busy  <= 1'b1;
          end
        end
      end else if (abort) begin
        phase <= PH_IDLE;
        A     <= 1'b0;
        busy  <= 1'b0;
        done  <= 1'b1;
        err   <= 1'b1;
      end else if (expire) begin
        k2_seen <= 1'b0;
        k1_seen <= 1'b0;
        case (phase)
          PH_1: begin phase <= PH_2; A <= 1'b0; end
          PH_2: begin phase <= PH_3; A <= 1'b1; end
          PH_3: begin phase <= PH_4; A <= 1'b0; end
          PH_4: begin
            rounds_done <= rounds_done + ONE_R;
            if (last_round) begin
              phase <= PH_IDLE;
              A     <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              phase <= PH_1;
              A     <= 1'b1;
            end
          end
          default: begin phase <= PH_IDLE; A <= 1'b0; busy <= 1'b0; end
        endcase
      end else begin
        if (phase == PH_3 && K2) k2_seen <= 1'b1;
        if (phase == PH_4 && K1) k1_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Bench for fsm_seq_ctrl with a behavioural Idle/Start/Stop/Clear FSM attached.
// Expected waveforms come from the phase arithmetic: A = 1 when (k / L) is
// even, rounds_done = k / (4L), run length 4LN or the abort point.
module tb_fsm_seq_ctrl;
  import fsm_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       start;
  logic [7:0] hold_cycles, num_rounds;
  logic       K2, K1, A, busy, done, err;
  logic [7:0] rounds_done;

  fsm_state_e fst;
  logic       k2_fsm, k1_fsm;
  logic       kill_k2, kill_k1, inj_k1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 Clock = ~Clock;

  assign K2 = k2_fsm & ~kill_k2;
  assign K1 = (k1_fsm & ~kill_k1) | inj_k1;

  fsm_seq_ctrl dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .start       (start),
    .hold_cycles (hold_cycles),
    .num_rounds  (num_rounds),
    .K2          (K2),
    .K1          (K1),
    .A           (A),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .rounds_done (rounds_done)
  );

  // Controlled FSM: synchronous reset, registered one-cycle K pulses.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      fst    <= FSM_IDLE;
      k2_fsm <= 1'b0;
      k1_fsm <= 1'b0;
    end else begin
      k2_fsm <= 1'b0;
      k1_fsm <= 1'b0;
      case (fst)
        FSM_IDLE:  if (A)  fst <= FSM_START;
        FSM_START: if (!A) fst <= FSM_STOP;
        FSM_STOP:  if (A)  begin fst <= FSM_CLEAR; k2_fsm <= 1'b1; end
        FSM_CLEAR: if (!A) begin fst <= FSM_IDLE;  k1_fsm <= 1'b1; end
        default:   fst <= FSM_IDLE;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " A"},      32'(A),           32'd0);
    chk({tag, " busy"},   32'(busy),        32'd0);
    chk({tag, " done"},   32'(done),        32'd0);
    chk({tag, " err"},    32'(err),         32'd0);
    chk({tag, " rounds"}, 32'(rounds_done), 32'd0);
  endtask

  // mode 0: clean, 1: K2 suppressed, 2: K1 suppressed, 3: stray K1 in PH1.
  // Faulty modes abort in round 1.
  task automatic run_seq(input int h, input int n, input int mode, input bit restart);
    int L, T;
    string tg;
    L = h + 2;
    if (n == 0)         T = 0;
    else if (mode == 1) T = 3 * L;
    else if (mode == 2) T = 4 * L;
    else if (mode == 3) T = 1;
    else                T = 4 * L * n;
    kill_k2     = (mode == 1);
    kill_k1     = (mode == 2);
    hold_cycles = 8'(h);
    num_rounds  = 8'(n);
    start       = 1'b1;
    for (int k = 0; k <= T + 1; k++) begin
      @(posedge Clock); #1;
      start = 1'b0;
      tg = $sformatf("h%0d n%0d m%0d k%0d", h, n, mode, k);
      if (k < T) begin
        chk({tg, " busy"},   32'(busy),        32'd1);
        chk({tg, " A"},      32'(A),           32'(((k / L) % 2) == 0));
        chk({tg, " done"},   32'(done),        32'd0);
        chk({tg, " err"},    32'(err),         32'd0);
        chk({tg, " rounds"}, 32'(rounds_done), 32'(k / (4 * L)));
      end else if (k == T) begin
        chk({tg, " busy"},   32'(busy),        32'd0);
        chk({tg, " A"},      32'(A),           32'd0);
        chk({tg, " done"},   32'(done),        32'd1);
        chk({tg, " err"},    32'(err),         32'((mode != 0) && (n != 0)));
        chk({tg, " rounds"}, 32'(rounds_done), (mode == 0) ? 32'(n) : 32'd0);
      end else begin
        chk({tg, " done1"},  32'(done),        32'd0);
        chk({tg, " busy1"},  32'(busy),        32'd0);
      end
      if (mode == 3) inj_k1 = (k == 0);
      if (restart && k == T / 2 && k < T) begin
        start       = 1'b1;
        hold_cycles = 8'($urandom_range(0, 5));
        num_rounds  = 8'($urandom_range(1, 9));
      end
    end
    kill_k2 = 1'b0;
    kill_k1 = 1'b0;
    inj_k1  = 1'b0;
  endtask

  task automatic reset_pulse();
    Reset = 1'b0;
    #1;
    chk_idle("rst");
    @(posedge Clock); #1;
    Reset = 1'b1;
  endtask

  initial begin
    Reset       = 1'b0;
    start       = 1'b0;
    hold_cycles = '0;
    num_rounds  = '0;
    kill_k2     = 1'b0;
    kill_k1     = 1'b0;
    inj_k1      = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    chk_idle("por");
    Reset = 1'b1;
    @(posedge Clock); #1;

    run_seq(0, 1, 0, 1'b0);
    run_seq(2, 3, 0, 1'b0);
    run_seq(0, 0, 0, 1'b0);
    run_seq(1, 2, 1, 1'b0);
    run_seq(1, 2, 2, 1'b0);
    run_seq(0, 1, 3, 1'b0);
    reset_pulse();

    // Reset in the middle of an H=1, N=4 run, then a clean run.
    hold_cycles = 8'd1;
    num_rounds  = 8'd4;
    start       = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(posedge Clock); #1;
      start = 1'b0;
    end
    chk("mid busy", 32'(busy), 32'd1);
    reset_pulse();
    run_seq(1, 2, 0, 1'b0);

    run_seq(1, 2, 0, 1'b1);

    repeat (14) begin
      int h, n, m;
      bit rs;
      h  = $urandom_range(0, 3);
      n  = $urandom_range(0, 3);
      m  = (n == 0) ? 0 : $urandom_range(0, 3);
      rs = 1'($urandom_range(0, 1));
      run_seq(h, n, m, rs);
      if (m == 3) reset_pulse();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
